// File: rtl/led_counter_system_pkg.sv
// Shared FSM state encodings and Gray-code helper for the LED counter.
package led_counter_system_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      PAUSE = 2'd2
   } state_t;

   // Operates on a 16-bit value; the upper bits of a narrower input are
   // zero, so the low N bits of the result are the N-bit Gray code.
   function automatic logic [15:0] gray_enc(input logic [15:0] b);
      return b ^ (b >> 1);
   endfunction

endpackage

// File: rtl/led_counter_system_tick_gen.sv
// Free-running divider: counts 0..DIVISOR-1 while enabled, holds otherwise.
// tick is combinational, high for the single cycle the divider sits at DIVISOR-1 while enabled.
module tick_gen #(
   parameter int DIVISOR = 100000000
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   input  logic clr,
   output logic tick
);

   localparam int W = $clog2(DIVISOR);
   localparam logic [W-1:0] LAST = W'(DIVISOR - 1);

   logic [W-1:0] cnt;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (en) begin
         if (cnt == LAST) cnt <= '0;
         else             cnt <= cnt + W'(1);
      end
   end

   assign tick = en && (cnt == LAST);

endmodule

// File: rtl/led_counter_system.sv
// Up/down LED counter with run/pause FSM, single-step and optional Gray display.
// leds and wrap are registered: an advance shows on the edge that updates the count.
module led_counter_system
   import led_counter_system_pkg::*;
#(
   parameter int N       = 4,
   parameter int DIVISOR = 100000000
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         run,
   input  logic         step,
   input  logic         dir_up,
   input  logic         mode_gray,
   input  logic         clear,
   output logic [N-1:0] leds,
   output logic         wrap,
   output logic [1:0]   state_o
);

   state_t       state, state_next;
   logic         step_d, step_pulse, tick, advance, wrap_next;
   logic [N-1:0] bin, bin_next;
   logic [15:0]  gray_next;

   tick_gen #(.DIVISOR(DIVISOR)) u_tick_gen (
      .clk  (clk),
      .rst  (rst),
      .en   (state == RUN),
      .clr  (clear),
      .tick (tick)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (run)  state_next = RUN;
         RUN:     if (!run) state_next = PAUSE;
         PAUSE:   if (run)  state_next = RUN;
         default:           state_next = IDLE;
      endcase
      if (clear) state_next = IDLE;
   end

   assign step_pulse = step & ~step_d;
   assign advance    = ((state == RUN) & tick) |
                       (((state == IDLE) | (state == PAUSE)) & step_pulse);

   always_comb begin
      bin_next  = bin;
      wrap_next = 1'b0;
      if (advance) begin
         bin_next  = dir_up ? bin + N'(1) : bin - N'(1);
         wrap_next = dir_up ? (bin == '1) : (bin == '0);
      end
   end

   assign gray_next = gray_enc(16'(bin_next));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         step_d <= 1'b0;
         bin    <= '0;
         leds   <= '0;
         wrap   <= 1'b0;
      end else begin
         step_d <= step;
         if (clear) begin
            bin  <= '0;
            leds <= '0;
            wrap <= 1'b0;
         end else begin
            bin  <= bin_next;
            leds <= mode_gray ? gray_next[N-1:0] : bin_next;
            wrap <= wrap_next;
         end
      end
   end

   assign state_o = state;

endmodule

// File: tb/tb_led_counter_system.sv
// Directed self-checking bench for led_counter_system at N=4, DIVISOR=4.
module tb_led_counter_system;

   logic       clk = 1'b0;
   logic       rst, run, step, dir_up, mode_gray, clear;
   logic [3:0] leds;
   logic       wrap;
   logic [1:0] state_o;

   int checks = 0;
   int errors = 0;

   logic [3:0] gray_tbl [16] = '{4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4, 4'hC,
                                 4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8, 4'h0};

   led_counter_system #(.N(4), .DIVISOR(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .run       (run),
      .step      (step),
      .dir_up    (dir_up),
      .mode_gray (mode_gray),
      .clear     (clear),
      .leds      (leds),
      .wrap      (wrap),
      .state_o   (state_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   task automatic edges(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      logic [3:0] prev;
      rst = 1'b0; run = 1'b0; step = 1'b0; dir_up = 1'b1; mode_gray = 1'b0; clear = 1'b0;
      #3;
      chk("rst_leds", leds, 0);
      chk("rst_wrap", wrap, 0);
      chk("rst_state", state_o, 0);
      edges(2);
      rst = 1'b1;
      edges(3);
      chk("idle_hold", state_o, 0);

      // binary up count, 16 ticks
      run = 1'b1;
      edges(1);
      chk("enter_run", state_o, 1);
      edges(3);
      chk("pre_tick1", leds, 0);
      edges(1);
      chk("bin_1", leds, 1);
      for (int k = 2; k <= 16; k++) begin
         edges(3);
         chk("bin_hold", leds, (k - 1) & 15);
         chk("bin_nowrap", wrap, 0);
         edges(1);
         chk("bin_adv", leds, k & 15);
         chk("bin_wrap", wrap, (k == 16) ? 1 : 0);
      end

      // Gray display, 16 ticks
      mode_gray = 1'b1;
      prev = 4'h0;
      for (int k = 0; k < 16; k++) begin
         edges(3);
         chk("gray_hold", leds, prev);
         edges(1);
         chk("gray_adv", leds, gray_tbl[k]);
         chk("gray_1bit", $countones(leds ^ prev), 1);
         chk("gray_wrap", wrap, (k == 15) ? 1 : 0);
         prev = gray_tbl[k];
      end

      // down count from 0
      mode_gray = 1'b0;
      dir_up = 1'b0;
      edges(3);
      chk("dn_hold", leds, 0);
      edges(1);
      chk("dn_15", leds, 15);
      chk("dn_wrap", wrap, 1);
      edges(4);
      chk("dn_14", leds, 14);
      chk("dn_nowrap", wrap, 0);

      // clear, 3 ticks, then pause and single-step
      dir_up = 1'b1;
      clear = 1'b1; run = 1'b0;
      edges(1);
      chk("clr_leds", leds, 0);
      chk("clr_state", state_o, 0);
      clear = 1'b0; run = 1'b1;
      edges(13);
      chk("run3", leds, 3);
      run = 1'b0;
      edges(1);
      chk("pause_state", state_o, 2);
      chk("pause_leds", leds, 3);
      step = 1'b1;
      edges(1);
      chk("step1", leds, 4);
      edges(4);
      chk("step_held", leds, 4);
      step = 1'b0;
      edges(2);
      step = 1'b1;
      edges(1);
      chk("step2", leds, 5);
      step = 1'b0;
      edges(1);
      chk("step_total", leds, 5);
      chk("step_state", state_o, 2);
      run = 1'b1;
      edges(1);
      chk("resume_state", state_o, 1);
      edges(2);
      chk("resume_pre", leds, 5);
      edges(1);
      chk("resume_tick", leds, 6);

      // step ignored in RUN
      step = 1'b1;
      edges(1);
      chk("run_step_ign", leds, 6);
      step = 1'b0;
      edges(2);

      // clear coincides with tick and step pulse
      clear = 1'b1; step = 1'b1;
      edges(1);
      chk("clrpri_leds", leds, 0);
      chk("clrpri_state", state_o, 0);
      chk("clrpri_wrap", wrap, 0);
      clear = 1'b0; step = 1'b0; run = 1'b0;
      edges(1);
      chk("post_clr", leds, 0);
      step = 1'b1;
      edges(1);
      chk("idle_step", leds, 1);
      step = 1'b0;

      // async reset mid-divider
      run = 1'b1;
      edges(6);
      chk("pre_arst", leds, 2);
      #3 rst = 1'b0;
      #1;
      chk("arst_leds", leds, 0);
      chk("arst_state", state_o, 0);
      chk("arst_wrap", wrap, 0);
      @(posedge clk);
      #1 rst = 1'b1;
      edges(4);
      chk("post_rst_pre", leds, 0);
      edges(1);
      chk("post_rst_tick", leds, 1);
      chk("post_rst_wrap", wrap, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/led_counter_system.md
LED_COUNTER_SYSTEM -- requirements
Module: led_counter_system

Interface
REQ-001 Parameter N, default 4: counter/LED width, legal range 2..16.
REQ-002 Parameter DIVISOR, default 100000000: clk cycles per count tick (1 Hz at 10 ns clk), legal minimum 2.
REQ-003 clk  in  1  single system clock, all state on rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-low.
REQ-005 run  in  1  level; 1 = count on ticks, 0 = hold (pre-synchronised).
REQ-006 step  in  1  single-step request, acted on at rising edge (pre-synchronised, debounced).
REQ-007 dir_up  in  1  1 = increment, 0 = decrement, sampled per advance.
REQ-008 mode_gray  in  1  1 = leds show Gray code, 0 = plain binary.
REQ-009 clear  in  1  synchronous clear of count, divider and FSM.
REQ-010 leds  out  N  registered display value.
REQ-011 wrap  out  1  registered one-cycle pulse on count wrap-around.
REQ-012 state_o  out  2  current FSM state encoding (IDLE=0, RUN=1, PAUSE=2).

Function
REQ-013 FSM states IDLE, RUN, PAUSE; IDLE->RUN when run=1; RUN->PAUSE when run=0; PAUSE->RUN when run=1; PAUSE stays PAUSE, IDLE stays IDLE otherwise.
REQ-014 Divider counts 0..DIVISOR-1 only in RUN, wraps to 0; tick = 1 for exactly one cycle when divider = DIVISOR-1.
REQ-015 On leaving RUN the divider is held at its value; on entering IDLE it is cleared.
REQ-016 step_pulse = step & ~step_d, step_d a registered copy of step (reset 0).
REQ-017 Advance = (state=RUN & tick) | (state in {IDLE, PAUSE} & step_pulse); step in RUN is ignored.
REQ-018 On advance, internal binary count bin (N bits) becomes bin+1 mod 2^N if dir_up=1, else bin-1 mod 2^N.
REQ-019 Each cycle leds <= mode_gray ? (bin_next ^ (bin_next>>1)) : bin_next; leds reflect an advance on the same edge bin updates (latency 1 cycle from tick/step edge), and a mode_gray change shows on the next edge.
REQ-020 wrap = 1 for one cycle when an advance takes bin from 2^N-1 to 0 (up) or from 0 to 2^N-1 (down).
REQ-021 clear=1: bin<=0, divider<=0, state<=IDLE, wrap<=0, leds<=0 on the next edge; clear takes priority over tick, step and run.
REQ-022 tick in the cycle run falls: state is still RUN, so the advance occurs, then PAUSE.
REQ-023 dir_up changes take effect at the next advance only; no glitch in leds between advances.

Reset
REQ-024 rst=0 asynchronously forces state=IDLE, bin=0, divider=0, step_d=0, leds=0, wrap=0, state_o=0.
REQ-025 After rst deasserts, first state change occurs at the first clk edge with run=1.
REQ-026 rst mid-count discards the partial divider value; no wrap pulse is generated by reset.

Structure
REQ-027 Shared package holds state typedef/encodings (IDLE, RUN, PAUSE) and a Gray encode function.
REQ-028 Divider is a sub-module tick_gen (params DIVISOR; ports clk, rst, en, clr, tick), width $clog2(DIVISOR).
REQ-029 Top holds FSM, step edge detect, binary counter and output registers; no combinational path from inputs to leds or wrap.

Verification (bench uses N=4, DIVISOR=4)
REQ-030 Reset, run=1, dir_up=1, mode_gray=0 for 16 ticks -> leds 1,2,...,15,0, one tick every 4 cycles, wrap pulse exactly at 15->0.
REQ-031 Same with mode_gray=1 -> leds 0001,0011,0010,0110,..., each successive value differs in exactly one bit.
REQ-032 From bin=0, run=1, dir_up=0 -> leds 15 after first tick with wrap=1, then 14.
REQ-033 run=0 after 3 ticks, step held high 5 cycles then low, pulsed twice -> leds advance by exactly 2, state_o=2; run=1 resumes counting from held divider value.
REQ-034 clear asserted same cycle as tick and step_pulse -> leds=0, state_o=0, wrap=0 next edge, no advance.
REQ-035 rst asserted mid-divider between clock edges -> outputs zero immediately, before next clk edge.
